// File: rtl/mem_pipe_reg.sv
// Pipeline register between EX and MEM with an optional two-entry skid buffer.
// Head entry drives the outputs straight from registers; control is masked while empty.
module mem_pipe_reg #(
  parameter int DATA_W  = 16,
  parameter int NCH     = 2,
  parameter int CTRL_W  = 1,
  parameter int SKID    = 1,
  parameter int STALL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NCH*DATA_W-1:0]   in_data,
  input  logic [CTRL_W-1:0]       in_ctrl,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NCH*DATA_W-1:0]   out_data,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [1:0]              occupancy,
  output logic [STALL_W-1:0]      stall_cnt
);

  localparam int W = NCH * DATA_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t              r_state;
  logic [W-1:0]        r_main_data;
  logic [W-1:0]        r_skid_data;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [STALL_W-1:0]  r_stall;

  logic w_accept;
  logic w_take;
  logic w_stall;

  // With a skid slot, ready is a pure register decode so it never waits on out_ready.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = (r_state != S_TWO);
    end else begin : g_noskid
      assign in_ready = (r_state == S_EMPTY) | out_ready;
    end
  endgenerate

  assign out_valid = (r_state != S_EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_take    = out_valid & out_ready;
  assign w_stall   = out_valid & ~out_ready;

  assign out_data  = r_main_data;
  assign out_ctrl  = out_valid ? r_main_ctrl : '0;
  assign stall_cnt = r_stall;

  always_comb begin
    occupancy = 2'd0;
    case (r_state)
      S_ONE:   occupancy = 2'd1;
      S_TWO:   occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else if (flush) begin
      r_state     <= S_EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_take) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end else if (w_accept && (SKID != 0)) begin
            // Head is stalled: park the newcomer behind it so out_data stays put.
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
            r_state     <= S_TWO;
          end else if (w_take) begin
            r_state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_take) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
            r_state     <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  // Back-pressure counter survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (w_stall && (r_stall != {STALL_W{1'b1}})) begin
      r_stall <= r_stall + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_pipe_reg.sv
// Random and directed checks of mem_pipe_reg (SKID=1 and SKID=0 side by side)
// against a FIFO-level reference model.
module tb_mem_pipe_reg;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic [31:0]       in_data = '0;
  logic [0:0]        in_ctrl = '0;
  logic              out_ready = 1'b0;

  logic [1:0]        rdy;
  logic [1:0]        ov;
  logic [1:0][31:0]  od;
  logic [1:0][0:0]   oc;
  logic [1:0][1:0]   occ;
  logic [1:0][7:0]   sc;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 0;

  // model: per instance (1 = skid, 0 = no skid) a small FIFO of {ctrl,data}
  logic [32:0] mq [2][2];
  int          mcnt [2];
  int          mstall [2];
  bit          mzero [2];

  always #5 clk = ~clk;

  mem_pipe_reg #(.DATA_W(16), .NCH(2), .CTRL_W(1), .SKID(1), .STALL_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_ctrl(oc[1]),
    .occupancy(occ[1]), .stall_cnt(sc[1])
  );

  mem_pipe_reg #(.DATA_W(16), .NCH(2), .CTRL_W(1), .SKID(0), .STALL_W(8)) dut_n (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_ctrl(oc[0]),
    .occupancy(occ[0]), .stall_cnt(sc[0])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic bit model_ready(input int k);
    if (k == 1) return mcnt[1] < 2;
    return (mcnt[0] == 0) || out_ready;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; mstall[k] = 0; mzero[k] = 1;
      mq[k][0] = '0; mq[k][1] = '0;
    end
  end

  // reference model advances on every rising edge from the inputs alone
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mcnt[k] = 0; mstall[k] = 0; mzero[k] = 1;
      end else begin
        bit vld, acc, tk;
        vld = mcnt[k] > 0;
        acc = in_valid && model_ready(k);
        tk  = vld && out_ready;
        if (vld && !out_ready && mstall[k] < 255) mstall[k]++;
        if (tk && k == 1)
          $display("take: data=%h ctrl=%0d t=%0t", mq[k][0][31:0], mq[k][0][32], $time);
        if (flush) begin
          mcnt[k] = 0; mzero[k] = 1;
        end else begin
          if (tk) begin mq[k][0] = mq[k][1]; mcnt[k]--; end
          if (acc) begin mq[k][mcnt[k]] = {in_ctrl, in_data}; mcnt[k]++; mzero[k] = 0; end
        end
      end
    end
  end

  // single compare process: every falling edge, both instances
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        bit vld;
        vld = mcnt[k] > 0;
        chk($sformatf("dut%0d.in_ready", k), 32'(rdy[k]), 32'(model_ready(k)));
        chk($sformatf("dut%0d.out_valid", k), 32'(ov[k]), 32'(vld));
        chk($sformatf("dut%0d.occupancy", k), 32'(occ[k]), 32'(mcnt[k]));
        chk($sformatf("dut%0d.stall_cnt", k), 32'(sc[k]), 32'(mstall[k]));
        chk($sformatf("dut%0d.out_ctrl", k), 32'(oc[k]), vld ? 32'(mq[k][0][32]) : 32'd0);
        if (vld) chk($sformatf("dut%0d.out_data", k), od[k], mq[k][0][31:0]);
        else if (mzero[k]) chk($sformatf("dut%0d.out_data_zero", k), od[k], 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input bit c, input bit ordy);
    in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    step(); step();
    chk_en = 1;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("reset.out_valid", 32'(ov[k]), 32'd0);
      chk("reset.occupancy", 32'(occ[k]), 32'd0);
      chk("reset.in_ready", 32'(rdy[k]), 32'd1);
      chk("reset.stall_cnt", 32'(sc[k]), 32'd0);
      chk("reset.out_data", od[k], 32'd0);
    end

    // first word passes with one cycle latency
    drive(1, 32'h1234_ABCD, 1, 1);
    step();
    chk("lat.out_valid", 32'(ov[1]), 32'd1);
    chk("lat.out_data", od[1], 32'h1234_ABCD);
    chk("lat.out_ctrl", 32'(oc[1]), 32'd1);
    drive(0, 32'h0, 0, 1);
    step();

    // fill both slots, then drain in order
    drive(1, 32'h0001_0002, 0, 0);
    step();
    chk("fill.occ1", 32'(occ[1]), 32'd1);
    drive(1, 32'h0003_0004, 0, 0);
    step();
    chk("fill.occ2", 32'(occ[1]), 32'd2);
    chk("fill.in_ready", 32'(rdy[1]), 32'd0);
    drive(0, 32'h0, 0, 1);
    chk("drain.A", od[1], 32'h0001_0002);
    step();
    chk("drain.B", od[1], 32'h0003_0004);
    chk("drain.in_ready", 32'(rdy[1]), 32'd1);
    step();
    chk("drain.empty", 32'(ov[1]), 32'd0);

    // stall counting and saturation in state TWO
    do_reset();
    drive(1, 32'hAAAA_0001, 1, 0);
    step();
    drive(1, 32'hBBBB_0002, 1, 0);
    step();
    drive(0, 32'h0, 0, 0);
    repeat (5) step();
    chk("stall.six_s", 32'(sc[1]), 32'd6);
    chk("stall.six_n", 32'(sc[0]), 32'd6);
    repeat (260) step();
    chk("stall.sat_s", 32'(sc[1]), 32'd255);
    chk("stall.sat_n", 32'(sc[0]), 32'd255);

    // flush in TWO with a simultaneous input
    flush = 1'b1;
    drive(1, 32'hCCCC_0003, 1, 0);
    step();
    flush = 1'b0;
    chk("flush.occ", 32'(occ[1]), 32'd0);
    chk("flush.out_valid", 32'(ov[1]), 32'd0);
    chk("flush.out_ctrl", 32'(oc[1]), 32'd0);
    chk("flush.out_data", od[1], 32'd0);
    chk("flush.stall_kept", 32'(sc[1]), 32'd255);
    drive(0, 32'h0, 0, 0);
    step();
    chk("flush.input_lost", 32'(ov[1]), 32'd0);

    // reset mid-transfer in TWO
    drive(1, 32'h1111_1111, 1, 0);
    step();
    drive(1, 32'h2222_2222, 1, 0);
    step();
    rst_n = 1'b0;
    drive(1, 32'h3333_3333, 1, 1);
    step();
    rst_n = 1'b1;
    drive(0, 32'h0, 0, 0);
    chk("rst2.occ", 32'(occ[1]), 32'd0);
    chk("rst2.stall", 32'(sc[1]), 32'd0);
    chk("rst2.in_ready", 32'(rdy[1]), 32'd1);

    // streaming, one word per cycle
    for (int i = 0; i < 100; i++) begin
      drive(1, 32'(i), 0, 1);
      step();
      chk("stream.valid", 32'(ov[1]), 32'd1);
      chk("stream.data", od[1], 32'(i));
    end
    drive(0, 32'h0, 0, 1);
    step();

    // no-skid instance: blocked when held, same-cycle replace when drained
    drive(1, 32'h5555_0005, 0, 0);
    step();
    drive(0, 32'h0, 0, 0);
    #1;
    chk("noskid.blocked", 32'(rdy[0]), 32'd0);
    chk("noskid.occ", 32'(occ[0]), 32'd1);
    drive(1, 32'h6666_0006, 1, 1);
    #1;
    chk("noskid.ready", 32'(rdy[0]), 32'd1);
    step();
    chk("noskid.replace", od[0], 32'h6666_0006);
    chk("noskid.occ_one", 32'(occ[0]), 32'd1);
    drive(0, 32'h0, 0, 1);
    step();

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 39) == 0);
      rst_n = ($urandom_range(0, 249) != 0);
      step();
    end
    flush = 1'b0;
    rst_n = 1'b1;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
